// File: rtl/command_dispatcher.sv
// command_dispatcher
// Accepts a 32-bit command stream (header word followed by payload words),
// buffers the payload and either dispatches the command to one of NUM_UNITS
// execution units over a start/done handshake or applies it to the local
// colour / viewport registers. Malformed commands are drained and reported
// through a sticky error flag; a watchdog aborts units that never finish.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command word handshake, cmd_data carries the word
//   cmd_data              header {opcode[31:24], flags[23:16], len[15:0]} or payload
//   unit_start/unit_done  per-unit one-cycle start pulse / completion pulse
//   payload_data          buffered payload, word i at [32i+31:32i]
//   payload_len           payload word count of the current dispatch
//   cur_flags             flags field of the current command
//   color, viewport       local state registers, viewport = {h, w, y, x}
//   busy                  high whenever the dispatcher is not idle
//   err, err_code         sticky error flag and first error code
//   err_clear             clears err and err_code
module command_dispatcher #(
    parameter int MAX_PAYLOAD    = 8,
    parameter int NUM_UNITS      = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cmd_valid,
    input  logic [31:0]                        cmd_data,
    output logic                               cmd_ready,
    output logic [NUM_UNITS-1:0]               unit_start,
    input  logic [NUM_UNITS-1:0]               unit_done,
    output logic [MAX_PAYLOAD*32-1:0]          payload_data,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]   payload_len,
    output logic [7:0]                         cur_flags,
    output logic [31:0]                        color,
    output logic [127:0]                       viewport,
    output logic                               busy,
    output logic                               err,
    output logic [1:0]                         err_code,
    input  logic                               err_clear
);

    localparam int IDX_W = $clog2(MAX_PAYLOAD);
    localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_SET_COLOR = 8'h10;
    localparam logic [7:0] OP_SET_VP    = 8'h11;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_BAD_OPCODE = 2'd1;
    localparam logic [1:0] ERR_BAD_LEN    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        DRAIN,
        DISPATCH,
        WAIT_DONE,
        APPLY
    } state_t;

    function automatic logic is_unit_op(input logic [7:0] op);
        return (op >= 8'd1) && (op <= 8'(NUM_UNITS));
    endfunction

    function automatic logic [1:0] header_error(input logic [7:0] op, input logic [15:0] len);
        if (op == OP_NOP)
            return (len == 16'd0) ? ERR_NONE : ERR_BAD_LEN;
        if (is_unit_op(op))
            return (len <= 16'(MAX_PAYLOAD)) ? ERR_NONE : ERR_BAD_LEN;
        if (op == OP_SET_COLOR)
            return (len == 16'd1) ? ERR_NONE : ERR_BAD_LEN;
        if (op == OP_SET_VP)
            return (len == 16'd4) ? ERR_NONE : ERR_BAD_LEN;
        return ERR_BAD_OPCODE;
    endfunction

    // One-hot select of the unit addressed by a unit opcode (opcode - 1).
    function automatic logic [NUM_UNITS-1:0] unit_mask(input logic [7:0] op);
        logic [NUM_UNITS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_UNITS; i++)
            m[i] = (op == 8'(i + 1));
        return m;
    endfunction

    state_t                 state;
    logic [7:0]             opcode_q;
    logic [15:0]            len_q;
    logic [15:0]            word_cnt;
    logic [TO_W-1:0]        tmo_cnt;
    logic [31:0]            words [MAX_PAYLOAD];

    logic [NUM_UNITS-1:0]   sel_mask;
    logic                   done_sel;
    logic [1:0]             hdr_err;
    logic                   last_word;
    logic                   tmo_hit;
    logic [1:0]             raise_code;

    for (genvar g = 0; g < MAX_PAYLOAD; g++) begin : g_payload
        assign payload_data[32*g +: 32] = words[g];
    end

    // Ready is gated by rst_n so it stays low for the whole reset interval.
    assign cmd_ready = rst_n && (state == IDLE || state == PAYLOAD || state == DRAIN);
    assign busy      = (state != IDLE);

    assign sel_mask  = unit_mask(opcode_q);
    assign done_sel  = |(unit_done & sel_mask);
    assign hdr_err   = header_error(cmd_data[31:24], cmd_data[15:0]);
    assign last_word = (word_cnt == len_q - 16'd1);
    // Done takes priority over the watchdog in the final WAIT_DONE cycle.
    assign tmo_hit   = (state == WAIT_DONE) && !done_sel && (tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        raise_code = ERR_NONE;
        if (state == IDLE && cmd_valid)
            raise_code = hdr_err;
        else if (tmo_hit)
            raise_code = ERR_TIMEOUT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            opcode_q    <= '0;
            len_q       <= '0;
            word_cnt    <= '0;
            tmo_cnt     <= '0;
            unit_start  <= '0;
            payload_len <= '0;
            cur_flags   <= '0;
            color       <= '0;
            viewport    <= '0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            for (int i = 0; i < MAX_PAYLOAD; i++)
                words[i] <= '0;
        end else begin
            unit_start <= '0;

            // A new error always wins over err_clear; only the first code sticks.
            if (raise_code != ERR_NONE) begin
                err <= 1'b1;
                if (!err || err_clear)
                    err_code <= raise_code;
            end else if (err_clear) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end

            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        opcode_q  <= cmd_data[31:24];
                        cur_flags <= cmd_data[23:16];
                        len_q     <= cmd_data[15:0];
                        word_cnt  <= '0;
                        for (int i = 0; i < MAX_PAYLOAD; i++)
                            words[i] <= '0;
                        if (hdr_err != ERR_NONE) begin
                            state <= (cmd_data[15:0] != 16'd0) ? DRAIN : IDLE;
                        end else if (cmd_data[15:0] != 16'd0) begin
                            state <= PAYLOAD;
                        end else if (is_unit_op(cmd_data[31:24])) begin
                            state       <= DISPATCH;
                            unit_start  <= unit_mask(cmd_data[31:24]);
                            payload_len <= '0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (cmd_valid) begin
                        words[word_cnt[IDX_W-1:0]] <= cmd_data;
                        word_cnt <= word_cnt + 16'd1;
                        if (last_word) begin
                            if (is_unit_op(opcode_q)) begin
                                state       <= DISPATCH;
                                unit_start  <= sel_mask;
                                payload_len <= len_q[LEN_W-1:0];
                            end else begin
                                state <= APPLY;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (cmd_valid) begin
                        word_cnt <= word_cnt + 16'd1;
                        if (last_word)
                            state <= IDLE;
                    end
                end
                DISPATCH: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done_sel || tmo_hit)
                        state <= IDLE;
                    else
                        tmo_cnt <= tmo_cnt + TO_W'(1);
                end
                APPLY: begin
                    if (opcode_q == OP_SET_COLOR)
                        color <= words[0];
                    else
                        viewport <= {words[3], words[2], words[1], words[0]};
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_command_dispatcher.sv
module tb_command_dispatcher;

    localparam int MP = 8;
    localparam int NU = 3;
    localparam int TO = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cmd_valid;
    logic [31:0]           cmd_data;
    logic                  cmd_ready;
    logic [NU-1:0]         unit_start;
    logic [NU-1:0]         unit_done;
    logic [MP*32-1:0]      payload_data;
    logic [3:0]            payload_len;
    logic [7:0]            cur_flags;
    logic [31:0]           color;
    logic [127:0]          viewport;
    logic                  busy;
    logic                  err;
    logic [1:0]            err_code;
    logic                  err_clear;

    command_dispatcher #(
        .MAX_PAYLOAD    (MP),
        .NUM_UNITS      (NU),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .unit_start   (unit_start),
        .unit_done    (unit_done),
        .payload_data (payload_data),
        .payload_len  (payload_len),
        .cur_flags    (cur_flags),
        .color        (color),
        .viewport     (viewport),
        .busy         (busy),
        .err          (err),
        .err_code     (err_code),
        .err_clear    (err_clear)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;

    logic [31:0]  wbuf [0:15];
    logic [31:0]  exp_color;
    logic [127:0] exp_vp;
    logic         exp_err;
    logic [1:0]   exp_code;

    typedef struct {
        logic [7:0] op;
        int         len;
        int         disp;
        int         code;
    } vec_t;

    vec_t tab [12];

    always @(negedge clk)
        if (unit_start != '0)
            n_starts <= n_starts + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference classification straight from the opcode map.
    function automatic int model_code(input logic [7:0] op, input int len);
        if (op == 8'h00) return (len == 0) ? 0 : 2;
        if (op >= 8'd1 && op <= 8'(NU)) return (len <= MP) ? 0 : 2;
        if (op == 8'h10) return (len == 1) ? 0 : 2;
        if (op == 8'h11) return (len == 4) ? 0 : 2;
        return 1;
    endfunction

    function automatic bit is_unit(input logic [7:0] op);
        return (op >= 8'd1) && (op <= 8'(NU));
    endfunction

    task automatic send_word(input logic [31:0] w, output bit stalled);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data  = w;
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_ready", 256'(cmd_ready), 256'(1));
        stalled = (n != 0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic clear_err();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        exp_err  = 1'b0;
        exp_code = 2'd0;
        chk("err_cleared", 256'({err, err_code}), 256'(0));
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [7:0] fl, input int len,
                           input int dly, input logic [NU-1:0] spur);
        int code, k, starts0;
        bit disp, st, any_stall;
        logic [NU-1:0] m;
        logic [255:0] exp_pd;
        code    = model_code(op, len);
        disp    = (code == 0) && is_unit(op);
        m       = disp ? (NU'(1) << (op - 8'd1)) : '0;
        starts0 = n_starts;
        exp_pd  = '0;
        send_word({op, fl, len[15:0]}, any_stall);
        for (int i = 0; i < len; i++) begin
            send_word(wbuf[i], st);
            any_stall |= st;
            if (i < MP) exp_pd[32*i +: 32] = wbuf[i];
        end
        chk("ready_no_stall", 256'(any_stall), 256'(0));
        if (code != 0) begin
            if (!exp_err) exp_code = code[1:0];
            exp_err = 1'b1;
        end
        if (disp) begin
            chk("start_pulse", 256'(unit_start), 256'(m));
            chk("payload_len", 256'(payload_len), 256'(len));
            chk("cur_flags", 256'(cur_flags), 256'(fl));
            chk("payload_data", payload_data, exp_pd);
            if (dly < 0) begin
                @(negedge clk);
                chk("start_width", 256'(unit_start), 256'(0));
                unit_done = spur & ~m;
                k = 0;
                while (busy && k < 100) begin
                    k++;
                    @(negedge clk);
                end
                unit_done = '0;
                chk("timeout_cycles", 256'(k), 256'(TO));
                if (!exp_err) exp_code = 2'd3;
                exp_err = 1'b1;
            end else begin
                for (int t = 1; t <= dly; t++) begin
                    @(negedge clk);
                    if (t == 1) chk("start_width", 256'(unit_start), 256'(0));
                    chk("busy_wait", 256'(busy), 256'(1));
                    if (t == dly)      unit_done = m | (spur & ~m);
                    else if (t == 1)   unit_done = spur & ~m;
                    else               unit_done = '0;
                end
                @(negedge clk);
                unit_done = '0;
                chk("busy_after_done", 256'(busy), 256'(0));
            end
        end else begin
            k = 0;
            while (busy && k < 5) begin
                k++;
                @(negedge clk);
            end
            chk("idle_reached", 256'(busy), 256'(0));
            if (code == 0 && op == 8'h10) exp_color = wbuf[0];
            if (code == 0 && op == 8'h11) exp_vp = {wbuf[3], wbuf[2], wbuf[1], wbuf[0]};
        end
        chk("start_count", 256'(n_starts - starts0), 256'(disp));
        chk("color", 256'(color), 256'(exp_color));
        chk("viewport", 256'(viewport), 256'(exp_vp));
        chk("err", 256'(err), 256'(exp_err));
        chk("err_code", 256'(err_code), 256'(exp_code));
    endtask

    task automatic check_reset_state();
        chk("rst_ready", 256'(cmd_ready), 256'(0));
        chk("rst_start", 256'(unit_start), 256'(0));
        chk("rst_payload", payload_data, 256'(0));
        chk("rst_plen", 256'(payload_len), 256'(0));
        chk("rst_flags", 256'(cur_flags), 256'(0));
        chk("rst_color", 256'(color), 256'(0));
        chk("rst_viewport", 256'(viewport), 256'(0));
        chk("rst_err", 256'({err, err_code}), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, pick, len, dly;
        bit st;
        logic [7:0] op;

        tab[0]  = '{8'h00, 0, 0, 0};
        tab[1]  = '{8'h00, 1, 0, 2};
        tab[2]  = '{8'h01, 0, 1, 0};
        tab[3]  = '{8'h03, 8, 1, 0};
        tab[4]  = '{8'h04, 0, 0, 1};
        tab[5]  = '{8'h10, 1, 0, 0};
        tab[6]  = '{8'h10, 0, 0, 2};
        tab[7]  = '{8'h11, 4, 0, 0};
        tab[8]  = '{8'h11, 3, 0, 2};
        tab[9]  = '{8'h12, 2, 0, 1};
        tab[10] = '{8'hFF, 0, 0, 1};
        tab[11] = '{8'h02, 9, 0, 2};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; unit_done = '0; err_clear = 1'b0;
        exp_color = '0; exp_vp = '0; exp_err = 1'b0; exp_code = 2'd0;
        for (int i = 0; i < 16; i++) wbuf[i] = '0;

        repeat (3) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 256'(cmd_ready), 256'(1));

        // SET_VIEWPORT x=0 y=0 w=4 h=3
        wbuf[0] = 0; wbuf[1] = 0; wbuf[2] = 4; wbuf[3] = 3;
        run_cmd(8'h11, 8'h00, 4, 0, '0);
        chk("viewport_const", 256'(viewport), 256'({32'd3, 32'd4, 32'd0, 32'd0}));

        // DRAW on unit 1, done five cycles after start
        wbuf[0] = 10; wbuf[1] = 10; wbuf[2] = 50; wbuf[3] = 10; wbuf[4] = 30; wbuf[5] = 40;
        run_cmd(8'h02, 8'h00, 6, 5, '0);
        chk("draw_word5", 256'(payload_data[32*5 +: 32]), 256'(40));

        // CLEAR with no payload; a done from unit 2 must be ignored
        run_cmd(8'h01, 8'h00, 0, 3, 3'b100);

        // Unknown opcode with payload, then a colour write
        wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
        run_cmd(8'h7F, 8'h00, 3, 0, '0);
        wbuf[0] = 32'hFF0000;
        run_cmd(8'h10, 8'h00, 1, 0, '0);
        chk("color_const", 256'(color), 256'(32'hFF0000));
        chk("badop_code", 256'(err_code), 256'(1));

        // Two length errors; first is kept, colour untouched
        clear_err();
        wbuf[0] = 32'h12345678; wbuf[1] = 32'h9;
        run_cmd(8'h10, 8'h00, 2, 0, '0);
        for (int i = 0; i < 9; i++) wbuf[i] = $urandom;
        run_cmd(8'h02, 8'h00, 9, 0, '0);
        chk("badlen_code", 256'(err_code), 256'(2));
        chk("color_kept", 256'(color), 256'(32'hFF0000));

        // Watchdog, then err_clear colliding with a new error
        clear_err();
        run_cmd(8'h01, 8'h00, 0, -1, 3'b110);
        chk("timeout_code", 256'(err_code), 256'(3));
        err_clear = 1'b1;
        send_word({8'h7F, 8'h00, 16'h0}, st);
        err_clear = 1'b0;
        exp_err = 1'b1; exp_code = 2'd1;
        chk("clear_vs_new_err", 256'(err), 256'(1));
        chk("clear_vs_new_code", 256'(err_code), 256'(1));

        // Opcode/length classification table
        for (int i = 0; i < 12; i++) begin
            clear_err();
            for (int j = 0; j < 16; j++) wbuf[j] = $urandom;
            b = n_starts;
            run_cmd(tab[i].op, 8'(i), tab[i].len, 1, '0);
            chk("tab_code", 256'(err_code), 256'(tab[i].code));
            chk("tab_disp", 256'(n_starts - b), 256'(tab[i].disp));
        end

        // Randomized command stream against the reference model
        for (int r = 0; r < 40; r++) begin
            pick = $urandom_range(0, 8);
            case (pick)
                0: op = 8'h00;
                1: op = 8'h01;
                2: op = 8'h02;
                3: op = 8'h03;
                4: op = 8'h04;
                5: op = 8'h10;
                6: op = 8'h11;
                7: op = 8'h7F;
                default: op = 8'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) len = $urandom_range(0, 11);
            else if (op == 8'h00) len = 0;
            else if (is_unit(op)) len = $urandom_range(0, MP);
            else if (op == 8'h10) len = 1;
            else if (op == 8'h11) len = 4;
            else len = $urandom_range(0, 3);
            for (int j = 0; j < 16; j++) wbuf[j] = $urandom;
            dly = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) clear_err();
            run_cmd(op, 8'($urandom), len, dly, NU'($urandom));
        end

        // Make state non-trivial, then reset in the middle of a DRAW payload
        wbuf[0] = 32'hCAFEF00D;
        run_cmd(8'h10, 8'h00, 1, 0, '0);
        run_cmd(8'h55, 8'h00, 0, 0, '0);
        wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3; wbuf[3] = 32'h4;
        run_cmd(8'h02, 8'hA5, 4, 2, '0);
        send_word({8'h02, 8'h5A, 16'd6}, st);
        send_word(32'h11, st);
        send_word(32'h22, st);
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        cmd_data = 32'hDEADBEEF;
        @(negedge clk);
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_midreset", 256'(cmd_ready), 256'(1));
        exp_color = '0; exp_vp = '0; exp_err = 1'b0; exp_code = 2'd0;

        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
        run_cmd(8'h02, 8'h3C, 3, 2, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
